// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
//   Handshake and operand bundle between the ID/EX pipeline register, the
//   multi-cycle ALU and the EX/MEM pipeline register.
//
//   Request side  : in_valid / in_ready, op, sa, a, b
//   Response side : out_valid / out_ready, c, v
//
//   master : the pipeline (drives requests, accepts results)
//   slave  : the ALU (accepts requests, drives results)
// -----------------------------------------------------------------------------
interface alu_mc_if #(
  parameter int WIDTH    = 32,
  parameter int SA_WIDTH = $clog2(WIDTH),
  parameter int OP_WIDTH = 5
);

  logic                in_valid;
  logic                in_ready;
  logic [OP_WIDTH-1:0] op;
  logic [SA_WIDTH-1:0] sa;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    c;
  logic                v;

  modport master (
    output in_valid, op, sa, a, b, out_ready,
    input  in_ready, out_valid, c, v
  );

  modport slave (
    input  in_valid, op, sa, a, b, out_ready,
    output in_ready, out_valid, c, v
  );

endinterface

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
//   Multi-cycle ALU for the RV32 execute stage. Base logic/compare/arith/shift
//   operations finish one cycle after acceptance; multiply (and, optionally,
//   divide/remainder) iterate one bit per cycle and finish WIDTH+1 cycles after
//   acceptance. Only one operation is in flight; the result is held until the
//   consumer takes it.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset, aborts any operation in flight
//     bus  - alu_mc_if.slave: in_valid/in_ready, op, sa, a, b,
//            out_valid/out_ready, c (result), v (overflow)
//
//   Build option:
//     ALU_MC_DIV_EN - when defined, the restoring divider and the div/rem
//                     opcodes are built; otherwise those opcodes complete
//                     immediately with c=0, v=0.
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH    = 32,
  parameter int SA_WIDTH = $clog2(WIDTH),
  parameter int OP_WIDTH = 5
) (
  input  logic    clk,
  input  logic    rst,
  alu_mc_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(5'b10000);
  localparam logic [OP_WIDTH-1:0] OP_MULHU = OP_WIDTH'(5'b10001);
`ifdef ALU_MC_DIV_EN
  localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(5'b10010);
  localparam logic [OP_WIDTH-1:0] OP_REMU  = OP_WIDTH'(5'b10011);
  localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(5'b10100);
  localparam logic [OP_WIDTH-1:0] OP_REM   = OP_WIDTH'(5'b10101);
  // The divider's partial remainder needs one guard bit for the trial subtract.
  localparam int HI_W = WIDTH + 1;
`else
  localparam int HI_W = WIDTH;
`endif

  state_t              state_q, state_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [SA_WIDTH-1:0] cnt_q, cnt_d;
  logic [HI_W-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic [WIDTH-1:0]    c_q, c_d;
  logic                v_q, v_d;
`ifdef ALU_MC_DIV_EN
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic                ovf_q, ovf_d;
`endif

  logic [WIDTH-1:0]    base_c;
  logic                base_v;
  logic [WIDTH-1:0]    sum_ab;
  logic [WIDTH-1:0]    diff_ab;
  logic [WIDTH:0]      mul_sum;
  logic [HI_W-1:0]     step_hi;
  logic [WIDTH-1:0]    step_lo;
  logic                is_mul;
`ifdef ALU_MC_DIV_EN
  logic                is_div;
  logic                is_sdiv;
  logic [WIDTH-1:0]    abs_a;
  logic [WIDTH-1:0]    abs_b;
  logic [WIDTH:0]      div_shift;
  logic [WIDTH:0]      div_trial;
`endif

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.c         = c_q;
  assign bus.v         = v_q;

  // Single-cycle result for the base opcodes, computed straight from the
  // request so it can be registered on the accept edge. Extended opcodes
  // leave this at zero, which is also the answer for unknown codes.
  always_comb begin
    base_c  = '0;
    base_v  = 1'b0;
    sum_ab  = bus.a + bus.b;
    diff_ab = bus.a - bus.b;
    if (!bus.op[OP_WIDTH-1]) begin
      casez (bus.op[3:0])
        4'b0001: base_c = bus.a | bus.b;
        4'b0101: base_c = ~(bus.a | bus.b);
        4'b0011: base_c = bus.a & bus.b;
        4'b0111: base_c = bus.a ^ bus.b;
        4'b0010: base_c = WIDTH'(bus.a == bus.b);
        4'b0000: base_c = WIDTH'(bus.a != bus.b);
        4'b0100: base_c = WIDTH'(bus.a[WIDTH-1] | ~|bus.a);
        4'b0110: base_c = WIDTH'(~bus.a[WIDTH-1] & |bus.a);
        4'b100?: begin
          base_c = sum_ab;
          base_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                   (sum_ab[WIDTH-1] != bus.a[WIDTH-1]);
        end
        4'b110?: begin
          base_c = diff_ab;
          base_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                   (diff_ab[WIDTH-1] != bus.a[WIDTH-1]);
        end
        4'b101?: base_c = bus.a << bus.sa;
        4'b1110: base_c = bus.a >> bus.sa;
        4'b1111: base_c = WIDTH'($signed(bus.a) >>> bus.sa);
        default: base_c = '0;
      endcase
    end
  end

  // Opcode classification of the incoming request.
  always_comb begin
    is_mul = (bus.op == OP_MUL) || (bus.op == OP_MULHU);
`ifdef ALU_MC_DIV_EN
    is_div  = (bus.op == OP_DIVU) || (bus.op == OP_REMU) ||
              (bus.op == OP_DIV)  || (bus.op == OP_REM);
    is_sdiv = (bus.op == OP_DIV)  || (bus.op == OP_REM);
    abs_a   = (is_sdiv && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b   = (is_sdiv && bus.b[WIDTH-1]) ? -bus.b : bus.b;
`endif
  end

  // One iteration of the shared multiply/divide datapath.
  // Multiply: {hi,lo} holds {partial product, remaining multiplier bits};
  // add the multiplicand when the multiplier LSB is set, then shift right.
  // Divide: {hi,lo} holds {partial remainder, remaining dividend bits};
  // shift left, keep the trial subtraction if it did not borrow, and shift
  // the quotient bit into lo. Operands are magnitudes; signs are fixed later.
  always_comb begin
    mul_sum = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    step_hi = HI_W'(mul_sum[WIDTH:1]);
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if ((op_q != OP_MUL) && (op_q != OP_MULHU)) begin
      if (div_trial[WIDTH]) begin
        step_hi = div_shift;
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        step_hi = div_trial;
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  // Next-state and datapath control. Requests are only looked at in IDLE, so
  // operand changes while busy or holding a result have no effect. Leaving
  // DONE never accepts in the same cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    c_d     = c_q;
    v_d     = v_q;
`ifdef ALU_MC_DIV_EN
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.op;
          if (is_mul) begin
            state_d = S_BUSY;
            cnt_d   = SA_WIDTH'(WIDTH - 1);
            hi_d    = '0;
            lo_d    = bus.b;
            opnd_d  = bus.a;
          end
`ifdef ALU_MC_DIV_EN
          else if (is_div) begin
            state_d = S_BUSY;
            cnt_d   = SA_WIDTH'(WIDTH - 1);
            hi_d    = '0;
            lo_d    = abs_a;
            opnd_d  = abs_b;
            // A zero divisor keeps the all-ones quotient unsigned; the
            // remainder sign follows A so that x rem 0 returns x.
            q_neg_d = is_sdiv && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && (|bus.b);
            r_neg_d = is_sdiv && bus.a[WIDTH-1];
            // MIN / -1 falls out of the magnitude datapath as quotient MIN and
            // remainder 0; only the flag needs remembering.
            ovf_d   = is_sdiv && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.b);
          end
`endif
          else begin
            state_d = S_DONE;
            c_d     = base_c;
            v_d     = base_v;
          end
        end
      end
      S_BUSY: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          v_d     = 1'b0;
          if (op_q == OP_MUL) begin
            c_d = step_lo;
          end else if (op_q == OP_MULHU) begin
            c_d = step_hi[WIDTH-1:0];
          end
`ifdef ALU_MC_DIV_EN
          else if ((op_q == OP_DIVU) || (op_q == OP_DIV)) begin
            c_d = q_neg_q ? -step_lo : step_lo;
            v_d = ovf_q;
          end else begin
            c_d = r_neg_q ? -step_hi[WIDTH-1:0] : step_hi[WIDTH-1:0];
            v_d = ovf_q;
          end
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset drops any result in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      c_q     <= '0;
      v_q     <= 1'b0;
`ifdef ALU_MC_DIV_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      c_q     <= c_d;
      v_q     <= v_d;
`ifdef ALU_MC_DIV_EN
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
//   Self-checking bench for alu_mc (WIDTH=32). Directed cases plus randomized
//   requests, compared against an arithmetic reference model. Div/rem
//   expectations follow ALU_MC_DIV_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  localparam int W = 32;

  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_LE    = 5'b00100;
  localparam logic [4:0] OP_GT    = 5'b00110;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_SUB   = 5'b01100;
  localparam logic [4:0] OP_SRL   = 5'b01110;
  localparam logic [4:0] OP_SRA   = 5'b01111;
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULHU = 5'b10001;
  localparam logic [4:0] OP_DIVU  = 5'b10010;
  localparam logic [4:0] OP_REMU  = 5'b10011;
  localparam logic [4:0] OP_DIV   = 5'b10100;
  localparam logic [4:0] OP_REM   = 5'b10101;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   failCount  = 0;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic on the operands.
  function automatic void refModel(input logic [4:0] op, input logic [4:0] sh,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] c, output logic v, output int lat);
    longint      sA;
    longint      sB;
    longint      wide;
    logic [63:0] prod;
    bit          sovf;
    sA   = longint'($signed(a));
    sB   = longint'($signed(b));
    prod = {32'b0, a} * {32'b0, b};
    sovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    c    = '0;
    v    = 1'b0;
    lat  = 1;
    if (!op[4]) begin
      case (op[3:0])
        4'h1: c = a | b;
        4'h5: c = ~(a | b);
        4'h3: c = a & b;
        4'h7: c = a ^ b;
        4'h2: c = (a == b) ? 32'd1 : 32'd0;
        4'h0: c = (a != b) ? 32'd1 : 32'd0;
        4'h4: c = (sA <= 0) ? 32'd1 : 32'd0;
        4'h6: c = (sA > 0) ? 32'd1 : 32'd0;
        4'h8, 4'h9: begin
          wide = sA + sB;
          c    = 32'(wide);
          v    = (wide != longint'($signed(c)));
        end
        4'hC, 4'hD: begin
          wide = sA - sB;
          c    = 32'(wide);
          v    = (wide != longint'($signed(c)));
        end
        4'hA, 4'hB: c = a << sh;
        4'hE:       c = a >> sh;
        4'hF:       c = 32'(sA >>> sh);
        default:    c = '0;
      endcase
    end else begin
      case (op)
        5'h10: begin c = prod[31:0];  lat = W + 1; end
        5'h11: begin c = prod[63:32]; lat = W + 1; end
`ifdef ALU_MC_DIV_EN
        5'h12: begin
          lat = W + 1;
          c   = (b == 0) ? 32'hFFFF_FFFF : a / b;
        end
        5'h13: begin
          lat = W + 1;
          c   = (b == 0) ? a : a % b;
        end
        5'h14: begin
          lat = W + 1;
          if (b == 0)    c = 32'hFFFF_FFFF;
          else if (sovf) begin c = a; v = 1'b1; end
          else           c = 32'(sA / sB);
        end
        5'h15: begin
          lat = W + 1;
          if (b == 0)    c = a;
          else if (sovf) begin c = '0; v = 1'b1; end
          else           c = 32'(sA % sB);
        end
`endif
        default: c = '0;
      endcase
    end
  endfunction

  // Issues one request (called just after a falling edge), scrambles the
  // inputs while it runs, checks latency/result, optionally stalls the
  // consumer for 'hold' cycles, then releases and checks the return to idle.
  task automatic applyStimulus(input string name, input logic [4:0] op, input logic [4:0] sh,
                               input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] expC;
    logic        expV;
    int          expLat;
    int          lat;
    refModel(op, sh, a, b, expC, expV, expLat);
    checkOutput({name, "_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.sa        = sh;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.op = 5'($urandom);
    bus.sa = 5'($urandom);
    bus.a  = $urandom;
    bus.b  = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, "_c"}, bus.c, expC);
    checkOutput({name, "_v"}, 32'(bus.v), 32'(expV));
    checkOutput({name, "_ready_busy"}, 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({name, "_hold_c"}, bus.c, expC);
      checkOutput({name, "_hold_v"}, 32'(bus.v), 32'(expV));
      checkOutput({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({name, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput({name, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    checkOutput({name, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Random operand biased toward the corner values.
  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] rop;
    logic       sawValid;

    // Reset with a request pending: reset must win.
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.sa        = '0;
    bus.a         = 32'd1;
    bus.b         = 32'd1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_c", bus.c, 32'd0);
    checkOutput("reset_v", 32'(bus.v), 32'd0);
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    @(negedge clk);

    // Directed cases.
    applyStimulus("add_ovf",  OP_ADD,   5'd0, 32'h7FFF_FFFF, 32'd1, 0);
    applyStimulus("sub_ovf",  OP_SUB,   5'd0, 32'h8000_0000, 32'd1, 0);
    applyStimulus("sra",      OP_SRA,   5'd4, 32'h8000_0000, 32'd0, 0);
    applyStimulus("srl",      OP_SRL,   5'd4, 32'h8000_0000, 32'd0, 0);
    applyStimulus("le_zero",  OP_LE,    5'd0, 32'd0, 32'd5, 0);
    applyStimulus("gt_neg",   OP_GT,    5'd0, 32'hFFFF_FFFF, 32'd5, 0);
    applyStimulus("mul",      OP_MUL,   5'd0, 32'hFFFF_FFFF, 32'd2, 0);
    applyStimulus("mulhu",    OP_MULHU, 5'd0, 32'hFFFF_FFFF, 32'd2, 0);
    applyStimulus("div",      OP_DIV,   5'd0, -32'sd7, 32'd2, 0);
    applyStimulus("rem",      OP_REM,   5'd0, -32'sd7, 32'd2, 0);
    applyStimulus("divu_z",   OP_DIVU,  5'd0, 32'd5, 32'd0, 0);
    applyStimulus("remu_z",   OP_REMU,  5'd0, 32'd5, 32'd0, 0);
    applyStimulus("div_ovf",  OP_DIV,   5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus("rem_ovf",  OP_REM,   5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus("or_hold",  OP_OR,    5'd0, 32'h1234_0000, 32'h0000_5678, 10);
    applyStimulus("unknown",  5'b11111, 5'd3, 32'hDEAD_BEEF, 32'h1, 0);

    // Reset in the middle of a multiply: nothing may come out afterwards.
    bus.in_valid  = 1'b1;
    bus.op        = OP_MUL;
    bus.a         = 32'd3;
    bus.b         = 32'd5;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("midbusy_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("abort_c", bus.c, 32'd0);
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("abort_no_stale", 32'(sawValid), 32'd0);

    // Randomized requests.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 0) rop = {1'b0, 4'($urandom)};
      else                           rop = 5'(16 + $urandom_range(0, 7));
      applyStimulus("rand", rop, 5'($urandom), pickOperand(), pickOperand(),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
